// File: rtl/rf_writeback_arbiter_if.sv
// Handshake and write-port bundle between the result producers and the
// register-file writeback arbiter.
interface rf_writeback_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5,
  parameter int CW   = 3
);
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            alu_ready;
  logic            lsu_valid;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic [AW-1:0]   wb_a3;
  logic [XLEN-1:0] wb_wd3;
  logic            wb_we3;
  logic [AW-1:0]   query_rd;
  logic            pend_hit;
  logic [CW-1:0]   fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, query_rd,
    input  alu_ready, lsu_ready, wb_a3, wb_wd3, wb_we3, pend_hit, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, query_rd,
    output alu_ready, lsu_ready, wb_a3, wb_wd3, wb_we3, pend_hit, fifo_count
  );
endinterface

// File: rtl/rf_writeback_arbiter.sv
// Merges ALU and buffered load results onto the single register-file write
// port, bounding how long ALU traffic may starve pending loads.
module rf_writeback_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic                  clk,
  input logic                  srst,
  rf_writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {GNT_NONE, GNT_ALU, GNT_LSU} grant_t;

  logic [AW-1:0]   rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] data_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;
  logic [AW-1:0]   wb_a3;
  logic [XLEN-1:0] wb_wd3;
  logic            wb_we3;
  logic            empty, full, force_fifo, push, pop, hit;
  grant_t          grant;

  assign empty      = (count == '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign force_fifo = !empty && (starve == SW'(STARVE_MAX));

  assign bus.alu_ready  = !srst && !force_fifo;
  assign bus.lsu_ready  = !srst && !full;
  assign bus.wb_a3      = wb_a3;
  assign bus.wb_wd3     = wb_wd3;
  assign bus.wb_we3     = wb_we3;
  assign bus.fifo_count = count;
  assign bus.pend_hit   = hit;

  always_comb begin
    grant = GNT_NONE;
    if (!srst) begin
      if (force_fifo)         grant = GNT_LSU;
      else if (bus.alu_valid) grant = GNT_ALU;
      else if (!empty)        grant = GNT_LSU;
    end
  end

  assign pop  = (grant == GNT_LSU);
  assign push = bus.lsu_valid && bus.lsu_ready;

  // The entry being popped still counts: its write lands in the register file next cycle.
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if ((CW'(i) < count) && (rd_q[rd_ptr + PW'(i)] == bus.query_rd))
        hit = 1'b1;
    end
    if (bus.query_rd == '0)
      hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      starve <= '0;
      wb_a3  <= '0;
      wb_wd3 <= '0;
      wb_we3 <= 1'b0;
    end else begin
      if (push) begin
        rd_q[wr_ptr]   <= bus.lsu_rd;
        data_q[wr_ptr] <= bus.lsu_data;
        wr_ptr         <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (pop || empty)
        starve <= '0;
      else if (grant == GNT_ALU && starve != SW'(STARVE_MAX))
        starve <= starve + SW'(1);

      case (grant)
        GNT_ALU: begin
          wb_a3  <= bus.alu_rd;
          wb_wd3 <= bus.alu_data;
          wb_we3 <= (bus.alu_rd != '0);
        end
        GNT_LSU: begin
          wb_a3  <= rd_q[rd_ptr];
          wb_wd3 <= data_q[rd_ptr];
          wb_we3 <= (rd_q[rd_ptr] != '0);
        end
        default: wb_we3 <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// Directed bench for rf_writeback_arbiter: hand-computed write-port, ready,
// occupancy and pending-hit expectations.
module tb_rf_writeback_arbiter;
  logic clk = 1'b0;
  logic srst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rf_writeback_arbiter_if #(.XLEN(32), .AW(5), .CW(3)) bus ();

  rf_writeback_arbiter #(
    .XLEN(32), .AW(5), .FIFO_DEPTH(4), .STARVE_MAX(3)
  ) u_dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic we, input logic [4:0] a3, input logic [31:0] wd);
    chk({tag, ".we3"}, 64'(bus.wb_we3), 64'(we));
    chk({tag, ".a3"},  64'(bus.wb_a3),  64'(a3));
    chk({tag, ".wd3"}, 64'(bus.wb_wd3), 64'(wd));
  endtask

  initial begin
    logic [4:0]  drain_rd [4];
    logic [31:0] drain_d  [4];
    drain_rd = '{5'd12, 5'd13, 5'd14, 5'd15};
    drain_d  = '{32'hB2, 32'hB3, 32'hB4, 32'hB5};

    srst          = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.lsu_valid = 1'b0;
    bus.lsu_rd    = '0;
    bus.lsu_data  = '0;
    bus.query_rd  = '0;
    tick();
    tick();
    chk("rst.alu_ready", 64'(bus.alu_ready), 64'd0);
    chk("rst.lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("rst.count", 64'(bus.fifo_count), 64'd0);
    chk_wb("rst", 1'b0, 5'd0, 32'h0);
    srst = 1'b0;

    // ALU-only write
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1 chk("alu.ready", 64'(bus.alu_ready), 64'd1);
    chk("alu.lsu_ready", 64'(bus.lsu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk_wb("alu.wb", 1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    chk_wb("alu.idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // x0 suppression, ALU then LSU
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1234;
    #1 chk("x0.alu_ready", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk_wb("x0.alu", 1'b0, 5'd0, 32'h1234);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd0; bus.lsu_data = 32'h55;
    tick();
    bus.lsu_valid = 1'b0;
    chk("x0.count1", 64'(bus.fifo_count), 64'd1);
    tick();
    chk("x0.count0", 64'(bus.fifo_count), 64'd0);
    chk_wb("x0.lsu", 1'b0, 5'd0, 32'h55);

    // Starvation bound: push cycle + three ALU grants with FIFO non-empty
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h101;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'hA5;
    tick();
    bus.lsu_valid = 1'b0;
    chk_wb("stv.w1", 1'b1, 5'd1, 32'h101);
    for (int unsigned k = 2; k <= 4; k++) begin
      bus.alu_rd = 5'(k); bus.alu_data = 32'h100 + k;
      #1 chk("stv.alu_ready", 64'(bus.alu_ready), 64'd1);
      tick();
      chk_wb("stv.wk", 1'b1, 5'(k), 32'h100 + k);
    end
    bus.alu_rd = 5'd5; bus.alu_data = 32'h105;
    #1 chk("stv.forced", 64'(bus.alu_ready), 64'd0);
    tick();
    chk_wb("stv.lsu", 1'b1, 5'd7, 32'hA5);
    chk("stv.count", 64'(bus.fifo_count), 64'd0);
    chk("stv.resume", 64'(bus.alu_ready), 64'd1);
    tick();
    bus.alu_valid = 1'b0;
    chk_wb("stv.w5", 1'b1, 5'd5, 32'h105);

    // FIFO full under ALU pressure, fifth push stalls until a pop
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hB1;
    tick();
    chk("full.c1", 64'(bus.fifo_count), 64'd1);
    bus.lsu_rd = 5'd12; bus.lsu_data = 32'hB2;
    tick();
    chk("full.c2", 64'(bus.fifo_count), 64'd2);
    bus.lsu_rd = 5'd13; bus.lsu_data = 32'hB3;
    tick();
    chk("full.c3", 64'(bus.fifo_count), 64'd3);
    bus.lsu_rd = 5'd14; bus.lsu_data = 32'hB4;
    tick();
    bus.lsu_rd = 5'd15; bus.lsu_data = 32'hB5;
    #1 chk("full.c4", 64'(bus.fifo_count), 64'd4);
    chk("full.lsu_ready", 64'(bus.lsu_ready), 64'd0);
    chk("full.alu_ready", 64'(bus.alu_ready), 64'd0);
    tick();
    chk("full.after_pop", 64'(bus.fifo_count), 64'd3);
    chk("full.lsu_ready1", 64'(bus.lsu_ready), 64'd1);
    chk_wb("full.b1", 1'b1, 5'd11, 32'hB1);
    tick();
    bus.lsu_valid = 1'b0; bus.alu_valid = 1'b0;
    chk("full.refill", 64'(bus.fifo_count), 64'd4);
    chk_wb("full.alu", 1'b1, 5'd10, 32'hA0);
    for (int unsigned k = 0; k < 4; k++) begin
      tick();
      chk_wb("full.drain", 1'b1, drain_rd[k], drain_d[k]);
    end
    chk("full.empty", 64'(bus.fifo_count), 64'd0);

    // Pending-load hazard query
    bus.query_rd = 5'd9;
    #1 chk("pend.empty", 64'(bus.pend_hit), 64'd0);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    tick();
    bus.lsu_valid = 1'b0;
    chk("pend.hit", 64'(bus.pend_hit), 64'd1);
    bus.query_rd = 5'd8;
    #1 chk("pend.miss", 64'(bus.pend_hit), 64'd0);
    bus.query_rd = 5'd9;
    tick();
    bus.alu_valid = 1'b0;
    #1 chk("pend.pop_cycle", 64'(bus.pend_hit), 64'd1);
    bus.query_rd = 5'd0;
    #1 chk("pend.x0", 64'(bus.pend_hit), 64'd0);
    bus.query_rd = 5'd9;
    tick();
    chk("pend.retired", 64'(bus.pend_hit), 64'd0);
    chk_wb("pend.wb", 1'b1, 5'd9, 32'h99);

    // Reset while three loads are buffered
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'h20;
    bus.lsu_valid = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      bus.lsu_rd = 5'(21 + k); bus.lsu_data = 32'hC0 + k;
      tick();
    end
    bus.lsu_valid = 1'b0;
    bus.query_rd  = 5'd21;
    srst = 1'b1;
    #1 chk("mid.count3", 64'(bus.fifo_count), 64'd3);
    chk("mid.hit", 64'(bus.pend_hit), 64'd1);
    chk("mid.alu_ready", 64'(bus.alu_ready), 64'd0);
    tick();
    srst = 1'b0; bus.alu_valid = 1'b0;
    chk("mid.count0", 64'(bus.fifo_count), 64'd0);
    chk("mid.pend", 64'(bus.pend_hit), 64'd0);
    chk_wb("mid.rst", 1'b0, 5'd0, 32'h0);
    for (int unsigned k = 0; k < 3; k++) begin
      tick();
      chk("mid.no_stale", 64'(bus.wb_we3), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
